// File: rtl/sev_seg_pkg.sv
// Shared seven-segment definitions: anode encodings, segment codes,
// and nibble/segment conversion used by the driver and capture monitor.
package sev_seg_pkg;

  typedef enum logic [7:0] {
    a0 = 8'b1111_1110,
    a1 = 8'b1111_1101,
    a2 = 8'b1111_1011,
    a3 = 8'b1111_0111,
    a4 = 8'b1110_1111,
    a5 = 8'b1101_1111,
    a6 = 8'b1011_1111,
    a7 = 8'b0111_1111
  } anode_t;

  typedef enum logic [1:0] {
    HUNT,
    COLLECT,
    COMPARE
  } cap_state_t;

  localparam logic [6:0] SEG_0 = 7'b0000001;
  localparam logic [6:0] SEG_1 = 7'b1001111;
  localparam logic [6:0] SEG_2 = 7'b0010010;
  localparam logic [6:0] SEG_3 = 7'b0000110;
  localparam logic [6:0] SEG_4 = 7'b1001100;
  localparam logic [6:0] SEG_5 = 7'b0100100;
  localparam logic [6:0] SEG_6 = 7'b0100000;
  localparam logic [6:0] SEG_7 = 7'b0001111;
  localparam logic [6:0] SEG_8 = 7'b0000000;
  localparam logic [6:0] SEG_9 = 7'b0000100;
  localparam logic [6:0] SEG_A = 7'b0001000;
  localparam logic [6:0] SEG_B = 7'b1100000;
  localparam logic [6:0] SEG_C = 7'b0110001;
  localparam logic [6:0] SEG_D = 7'b1000010;
  localparam logic [6:0] SEG_E = 7'b0110000;
  localparam logic [6:0] SEG_F = 7'b0111000;

  localparam logic [6:0] SEG_TAB [16] = '{
    SEG_0, SEG_1, SEG_2, SEG_3,
    SEG_4, SEG_5, SEG_6, SEG_7,
    SEG_8, SEG_9, SEG_A, SEG_B,
    SEG_C, SEG_D, SEG_E, SEG_F
  };

  // Returns {legal, nibble}; only exact table matches are legal.
  function automatic logic [4:0] seg_to_nibble(
    input logic [6:0] seg
  );
    logic [4:0] r;
    r = 5'b0_0000;
    for (int i = 0; i < 16; i++) begin
      if (seg == SEG_TAB[i]) begin
        r = {1'b1, 4'(i)};
      end
    end
    return r;
  endfunction

  function automatic logic [6:0] nibble_to_seg(
    input logic [3:0] nib
  );
    return SEG_TAB[nib];
  endfunction

endpackage

// File: rtl/sev_seg_capture_decode.sv
// Combinational decode of the sampled anode and segment lines
// into a digit index and a hex nibble, each with a validity flag.
module sev_seg_decode
  import sev_seg_pkg::*;
(
  input  logic [7:0] an,
  input  logic [6:0] sev_out,
  output logic       onehot_ok,
  output logic [2:0] index,
  output logic       legal,
  output logic [3:0] nibble
);

  logic [3:0] zeros;

  always_comb begin
    zeros = 4'd0;
    index = 3'd0;
    for (int i = 0; i < 8; i++) begin
      if (!an[i]) begin
        zeros = zeros + 4'd1;
        index = 3'(i);
      end
    end
    onehot_ok = (zeros == 4'd1);
  end

  always_comb begin
    {legal, nibble} = seg_to_nibble(sev_out);
  end

endmodule

// File: rtl/sev_seg_capture.sv
// Loopback monitor: reassembles the 32-bit word shown on the
// multiplexed 8-digit display and reports it once stable.
module sev_seg_capture
  import sev_seg_pkg::*;
#(
  parameter int FRAMES_STABLE = 2
) (
  input  logic        clk_7seg,
  input  logic        Rst,
  input  logic [7:0]  an,
  input  logic [6:0]  sev_out,
  output logic [31:0] value,
  output logic        value_valid,
  output logic        frame_done,
  output logic        seq_err,
  output logic        code_err
);

  localparam logic [3:0] STABLE_MAX = 4'(FRAMES_STABLE);

  cap_state_t state, state_nx;

  logic        onehot_ok;
  logic [2:0]  idx;
  logic        legal;
  logic [3:0]  nibble;

  logic [2:0]  exp_idx;
  logic [31:0] word;
  logic [31:0] full_word;
  logic [31:0] prev_word;
  logic [3:0]  stable_cnt;
  logic [3:0]  cnt_nx;

  logic        load;
  logic        last;
  logic        seq_d;
  logic        code_d;

  sev_seg_decode u_decode (
    .an        (an),
    .sev_out   (sev_out),
    .onehot_ok (onehot_ok),
    .index     (idx),
    .legal     (legal),
    .nibble    (nibble)
  );

  always_comb begin
    full_word = word;
    full_word[{idx, 2'b00} +: 4] = nibble;
  end

  always_comb begin
    cnt_nx = 4'd1;
    if (full_word == prev_word) begin
      cnt_nx = (stable_cnt >= STABLE_MAX) ?
               STABLE_MAX : stable_cnt + 4'd1;
    end
  end

  // The frame is judged on the edge that accepts digit 7, so the
  // COMPARE cycle itself is free to start the next frame.
  always_comb begin
    state_nx = state;
    load     = 1'b0;
    last     = 1'b0;
    seq_d    = 1'b0;
    code_d   = 1'b0;
    unique case (state)
      HUNT, COMPARE: begin
        state_nx = HUNT;
        if (onehot_ok && idx == 3'd0 && legal) begin
          load     = 1'b1;
          state_nx = COLLECT;
        end
      end
      COLLECT: begin
        seq_d  = !onehot_ok || (idx != exp_idx);
        code_d = !legal;
        if (seq_d || code_d) begin
          state_nx = HUNT;
        end else begin
          load = 1'b1;
          if (idx == 3'd7) begin
            last     = 1'b1;
            state_nx = COMPARE;
          end
        end
      end
      default: state_nx = HUNT;
    endcase
  end

  always_ff @(posedge clk_7seg) begin
    if (Rst) begin
      state       <= HUNT;
      exp_idx     <= 3'd0;
      word        <= 32'd0;
      prev_word   <= 32'd0;
      stable_cnt  <= 4'd0;
      value       <= 32'd0;
      value_valid <= 1'b0;
      frame_done  <= 1'b0;
      seq_err     <= 1'b0;
      code_err    <= 1'b0;
    end else begin
      state      <= state_nx;
      frame_done <= last;
      seq_err    <= seq_d;
      code_err   <= code_d;
      if (load) begin
        word    <= full_word;
        exp_idx <= idx + 3'd1;
      end
      if (last) begin
        prev_word  <= full_word;
        stable_cnt <= cnt_nx;
        if (cnt_nx == STABLE_MAX) begin
          value       <= full_word;
          value_valid <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_sev_seg_capture.sv
// Scoreboard bench for sev_seg_capture: directed scanner frames,
// expected events queued at stimulus time and checked by a monitor.
module tb_sev_seg_capture;

  localparam int FS = 2;

  logic        clk_7seg = 1'b0;
  logic        Rst      = 1'b1;
  logic [7:0]  an       = 8'hFF;
  logic [6:0]  sev_out  = 7'h7F;
  logic [31:0] value;
  logic        value_valid;
  logic        frame_done;
  logic        seq_err;
  logic        code_err;

  sev_seg_capture #(.FRAMES_STABLE(FS)) dut (
    .clk_7seg    (clk_7seg),
    .Rst         (Rst),
    .an          (an),
    .sev_out     (sev_out),
    .value       (value),
    .value_valid (value_valid),
    .frame_done  (frame_done),
    .seq_err     (seq_err),
    .code_err    (code_err)
  );

  always #5 clk_7seg = ~clk_7seg;

  int cyc = 0;
  always @(posedge clk_7seg) cyc++;

  typedef struct {
    logic        fd;
    logic        se;
    logic        ce;
    logic [31:0] val;
    logic        vv;
    int          at;
  } ev_t;

  ev_t exp_q[$];
  ev_t mon_e;
  int  checks   = 0;
  int  failures = 0;

  logic [6:0] seg_tab [16] = '{
    7'b0000001, 7'b1001111, 7'b0010010, 7'b0000110,
    7'b1001100, 7'b0100100, 7'b0100000, 7'b0001111,
    7'b0000000, 7'b0000100, 7'b0001000, 7'b1100000,
    7'b0110001, 7'b1000010, 7'b0110000, 7'b0111000
  };

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] req);
    checks++;
    if (act !== req) begin
      failures++;
      $display("FAIL %s actual=%h required=%h t=%0t",
               name, act, req, $time);
    end
  endtask

  always @(negedge clk_7seg) begin
    if (frame_done || seq_err || code_err) begin
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL unexpected_event actual=%b%b%b required=none cyc=%0d",
                 frame_done, seq_err, code_err, cyc);
      end else begin
        mon_e = exp_q.pop_front();
        check("event_kind", {29'd0, frame_done, seq_err, code_err},
              {29'd0, mon_e.fd, mon_e.se, mon_e.ce});
        check("event_cycle", cyc, mon_e.at);
        check("value", value, mon_e.val);
        check("value_valid", {31'd0, value_valid}, {31'd0, mon_e.vv});
      end
    end
  end

  task automatic expect_ev(input logic fd, input logic se,
                           input logic ce, input logic [31:0] v,
                           input logic vv);
    exp_q.push_back('{fd, se, ce, v, vv, cyc + 1});
  endtask

  task automatic drive(input logic [7:0] a, input logic [6:0] s);
    an      = a;
    sev_out = s;
    @(posedge clk_7seg);
    #1;
  endtask

  function automatic logic [7:0] an_of(input int k);
    return ~(8'd1 << k);
  endfunction

  task automatic digits(input logic [31:0] w, input int n);
    for (int k = 0; k < n; k++) begin
      drive(an_of(k), seg_tab[w[4*k +: 4]]);
    end
  endtask

  task automatic send_frame(input logic [31:0] w,
                            input logic [31:0] v,
                            input logic vv);
    digits(w, 7);
    expect_ev(1'b1, 1'b0, 1'b0, v, vv);
    drive(an_of(7), seg_tab[w[31:28]]);
  endtask

  task automatic check_all_zero(input string tag);
    check({tag, "_value"}, value, 32'd0);
    check({tag, "_vv"}, {31'd0, value_valid}, 32'd0);
    check({tag, "_fd"}, {31'd0, frame_done}, 32'd0);
    check({tag, "_se"}, {31'd0, seq_err}, 32'd0);
    check({tag, "_ce"}, {31'd0, code_err}, 32'd0);
  endtask

  initial begin
    repeat (3) drive(8'hFF, 7'h7F);
    check_all_zero("reset");
    Rst = 1'b0;
    drive(8'hFF, 7'h7F);

    send_frame(32'h1234ABCD, 32'h0, 1'b0);
    send_frame(32'h1234ABCD, 32'h1234ABCD, 1'b1);
    send_frame(32'hDEADBEEF, 32'h1234ABCD, 1'b1);
    send_frame(32'hDEADBEEF, 32'hDEADBEEF, 1'b1);

    digits(32'h1234ABCD, 3);
    expect_ev(1'b0, 1'b1, 1'b0, 32'hDEADBEEF, 1'b1);
    drive(an_of(4), seg_tab[4'hB]);

    drive(an_of(3), seg_tab[4'h2]);
    drive(an_of(5), 7'h7F);
    drive(8'hFF, 7'h7F);

    send_frame(32'h1234ABCD, 32'hDEADBEEF, 1'b1);
    send_frame(32'h1234ABCD, 32'h1234ABCD, 1'b1);

    digits(32'h55555555, 5);
    expect_ev(1'b0, 1'b0, 1'b1, 32'h1234ABCD, 1'b1);
    drive(an_of(5), 7'h7F);
    send_frame(32'h1234ABCD, 32'h1234ABCD, 1'b1);

    digits(32'h00000077, 2);
    expect_ev(1'b0, 1'b1, 1'b0, 32'h1234ABCD, 1'b1);
    drive(8'b1111_1100, seg_tab[4'h7]);

    digits(32'h00000009, 1);
    expect_ev(1'b0, 1'b1, 1'b1, 32'h1234ABCD, 1'b1);
    drive(an_of(3), 7'h7F);

    digits(32'h99999999, 4);
    Rst = 1'b1;
    drive(an_of(4), seg_tab[4'h9]);
    check_all_zero("midreset");
    Rst = 1'b0;
    drive(8'hFF, 7'h7F);

    send_frame(32'hCAFEF00D, 32'h0, 1'b0);
    send_frame(32'hCAFEF00D, 32'hCAFEF00D, 1'b1);

    repeat (3) drive(8'hFF, 7'h7F);
    check("queue_empty", exp_q.size(), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
